// File: rtl/pipeline_pkg.sv
// Shared defaults, E/M control-bundle bit layout, occupancy states and payload type
// for the MIPS pipeline boundary registers.
package pipeline_pkg;

    localparam int DEFAULT_DATA_WIDTH     = 32;
    localparam int DEFAULT_REG_ADDR_WIDTH = 5;
    localparam int EM_NUM_LANES           = 4;
    localparam int EM_CTRL_WIDTH          = 4;

    // Bit positions inside the E/M control bundle
    localparam int CTRL_REG_WRITE  = 0;
    localparam int CTRL_MEM_TO_REG = 1;
    localparam int CTRL_MEM_WRITE  = 2;
    localparam int CTRL_HILO_WRITE = 3;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_state_e;

    typedef struct packed {
        logic [EM_CTRL_WIDTH-1:0]                         ctrl;
        logic [EM_NUM_LANES-1:0][DEFAULT_DATA_WIDTH-1:0]  data;
        logic [DEFAULT_REG_ADDR_WIDTH-1:0]                dest;
    } em_payload_t;

endpackage

// File: rtl/pipeline_stage_register_if.sv
// Upstream/downstream valid-ready bundle of one pipeline boundary register.
interface pipeline_stage_register_if
    import pipeline_pkg::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int NUM_LANES      = EM_NUM_LANES,
    parameter int CTRL_WIDTH     = EM_CTRL_WIDTH,
    parameter int REG_ADDR_WIDTH = DEFAULT_REG_ADDR_WIDTH
);

    logic                            in_valid;
    logic                            in_ready;
    logic [CTRL_WIDTH-1:0]           ctrl_in;
    logic [NUM_LANES*DATA_WIDTH-1:0] data_in;
    logic [REG_ADDR_WIDTH-1:0]       dest_in;

    logic                            out_valid;
    logic                            out_ready;
    logic [CTRL_WIDTH-1:0]           ctrl_out;
    logic [NUM_LANES*DATA_WIDTH-1:0] data_out;
    logic [REG_ADDR_WIDTH-1:0]       dest_out;

    // master: the surrounding stages; slave: the boundary register itself
    modport master (
        output in_valid, ctrl_in, data_in, dest_in, out_ready,
        input  in_ready, out_valid, ctrl_out, data_out, dest_out
    );

    modport slave (
        input  in_valid, ctrl_in, data_in, dest_in, out_ready,
        output in_ready, out_valid, ctrl_out, data_out, dest_out
    );

endinterface

// File: rtl/pipeline_payload_slot.sv
// One payload register (ctrl, lanes, dest) with load enable and synchronous clear.
module pipeline_payload_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (clear) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipeline_stage_register.sv
// Parametrised valid/ready pipeline boundary register with flush, optional
// two-entry skid buffer and a saturating back-pressure counter.
module pipeline_stage_register
    import pipeline_pkg::*;
#(
    parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
    parameter int NUM_LANES       = EM_NUM_LANES,
    parameter int CTRL_WIDTH      = EM_CTRL_WIDTH,
    parameter int REG_ADDR_WIDTH  = DEFAULT_REG_ADDR_WIDTH,
    parameter bit SKID_ENABLE     = 1'b1,
    parameter int STALL_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    pipeline_stage_register_if.slave   bus,
    output logic [1:0]                 occupancy,
    output logic [STALL_CNT_WIDTH-1:0] stall_count
);

    localparam int LANES_W   = NUM_LANES * DATA_WIDTH;
    localparam int PAYLOAD_W = CTRL_WIDTH + LANES_W + REG_ADDR_WIDTH;
    localparam logic [STALL_CNT_WIDTH-1:0] STALL_ONE = STALL_CNT_WIDTH'(1);

    occ_state_e                 state_p1, state_next;
    logic                       out_valid, in_xfer, out_xfer;
    logic                       main_load, main_from_skid, skid_load;
    logic [PAYLOAD_W-1:0]       payload_in, main_d, main_q, skid_q;
    logic [STALL_CNT_WIDTH-1:0] stall_p1;

    function automatic logic [STALL_CNT_WIDTH-1:0] sat_inc(input logic [STALL_CNT_WIDTH-1:0] v);
        return (&v) ? v : v + STALL_ONE;
    endfunction

    assign out_valid = (state_p1 != OCC_EMPTY);

    // Skid mode decouples in_ready from out_ready entirely; it depends on state only
    if (SKID_ENABLE) begin : g_ready_skid
        assign bus.in_ready = (state_p1 != OCC_FULL);
    end else begin : g_ready_comb
        assign bus.in_ready = bus.out_ready | ~out_valid;
    end

    // An input offered during flush is dropped even when in_ready is high
    assign in_xfer    = bus.in_valid & bus.in_ready & ~flush;
    assign out_xfer   = out_valid & bus.out_ready;
    assign payload_in = {bus.ctrl_in, bus.data_in, bus.dest_in};
    assign main_d     = main_from_skid ? skid_q : payload_in;

    always_comb begin
        state_next     = state_p1;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        if (flush) begin
            state_next = OCC_EMPTY;
        end else begin
            case (state_p1)
                OCC_EMPTY: begin
                    if (in_xfer) begin
                        main_load  = 1'b1;
                        state_next = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_load = 1'b1;
                    end else if (in_xfer && SKID_ENABLE) begin
                        skid_load  = 1'b1;
                        state_next = OCC_FULL;
                    end else if (out_xfer) begin
                        state_next = OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    if (out_xfer) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        state_next     = OCC_ONE;
                    end
                end
                default: state_next = OCC_EMPTY;
            endcase
        end
    end

    // ---- stage boundary: occupancy state and stall counter ----
    always_ff @(posedge clk) begin
        if (reset) begin
            state_p1 <= OCC_EMPTY;
            stall_p1 <= '0;
        end else begin
            state_p1 <= state_next;
            if (out_valid && !bus.out_ready) begin
                stall_p1 <= sat_inc(stall_p1);
            end
        end
    end

    // ---- stage boundary: payload registers (flush leaves contents stale) ----
    pipeline_payload_slot #(.WIDTH(PAYLOAD_W)) u_main (
        .clk   (clk),
        .clear (reset),
        .load  (main_load),
        .d     (main_d),
        .q     (main_q)
    );

    if (SKID_ENABLE) begin : g_skid
        pipeline_payload_slot #(.WIDTH(PAYLOAD_W)) u_skid (
            .clk   (clk),
            .clear (reset),
            .load  (skid_load),
            .d     (payload_in),
            .q     (skid_q)
        );
    end else begin : g_no_skid
        assign skid_q = '0;
    end

    // Bubbles must never assert write enables downstream
    assign bus.out_valid = out_valid;
    assign bus.ctrl_out  = out_valid ? main_q[PAYLOAD_W-1 -: CTRL_WIDTH] : '0;
    assign bus.data_out  = main_q[REG_ADDR_WIDTH +: LANES_W];
    assign bus.dest_out  = main_q[REG_ADDR_WIDTH-1:0];
    assign occupancy     = state_p1;
    assign stall_count   = stall_p1;

endmodule

// File: tb/tb_pipeline_stage_register.sv
// Scoreboard bench: skid instance (A), combinational-ready instance (B) and a
// 4-bit stall counter instance (C).
module tb_pipeline_stage_register;
    import pipeline_pkg::*;

    localparam logic [3:0] C_LOAD  = 4'((1 << CTRL_REG_WRITE) | (1 << CTRL_MEM_TO_REG));
    localparam logic [3:0] C_STORE = 4'(1 << CTRL_MEM_WRITE);
    localparam logic [3:0] C_MULT  = 4'(1 << CTRL_HILO_WRITE);

    logic clk;
    logic rst_a, rst_b, rst_c;
    logic flush_a, flush_b, flush_c;
    logic [1:0]  occ_a, occ_b, occ_c;
    logic [15:0] stall_a, stall_b;
    logic [3:0]  stall_c;

    int n_cmp = 0;
    int n_bad = 0;

    em_payload_t exp_a[$];
    em_payload_t exp_b[$];

    pipeline_stage_register_if bus_a ();
    pipeline_stage_register_if bus_b ();
    pipeline_stage_register_if bus_c ();

    pipeline_stage_register #(.SKID_ENABLE(1'b1), .STALL_CNT_WIDTH(16)) u_a (
        .clk(clk), .reset(rst_a), .flush(flush_a), .bus(bus_a),
        .occupancy(occ_a), .stall_count(stall_a)
    );
    pipeline_stage_register #(.SKID_ENABLE(1'b0), .STALL_CNT_WIDTH(16)) u_b (
        .clk(clk), .reset(rst_b), .flush(flush_b), .bus(bus_b),
        .occupancy(occ_b), .stall_count(stall_b)
    );
    pipeline_stage_register #(.SKID_ENABLE(1'b1), .STALL_CNT_WIDTH(4)) u_c (
        .clk(clk), .reset(rst_c), .flush(flush_c), .bus(bus_c),
        .occupancy(occ_c), .stall_count(stall_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic em_payload_t mk(input logic [31:0] v, input logic [3:0] c, input logic [4:0] d);
        em_payload_t p;
        p.ctrl = c;
        p.dest = d;
        for (int i = 0; i < EM_NUM_LANES; i++) p.data[i] = v + 32'(i) * 32'h1000_0000;
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic vld, input em_payload_t p);
        bus_a.in_valid = vld; bus_a.ctrl_in = p.ctrl; bus_a.data_in = p.data; bus_a.dest_in = p.dest;
    endtask
    task automatic drive_b(input logic vld, input em_payload_t p);
        bus_b.in_valid = vld; bus_b.ctrl_in = p.ctrl; bus_b.data_in = p.data; bus_b.dest_in = p.dest;
    endtask
    task automatic drive_c(input logic vld, input em_payload_t p);
        bus_c.in_valid = vld; bus_c.ctrl_in = p.ctrl; bus_c.data_in = p.data; bus_c.dest_in = p.dest;
    endtask

    // Monitors: every output transfer must match the oldest outstanding entry
    always @(negedge clk) begin
        if (bus_a.out_valid === 1'b1 && bus_a.out_ready === 1'b1) begin
            if (exp_a.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL a_spurious_out: got lane0=%0h, required no output", bus_a.data_out[31:0]);
            end else begin
                em_payload_t e;
                e = exp_a.pop_front();
                chk("a_out_data", bus_a.data_out, e.data);
                chk("a_out_ctrl", bus_a.ctrl_out, e.ctrl);
                chk("a_out_dest", bus_a.dest_out, e.dest);
            end
        end
    end

    always @(negedge clk) begin
        if (bus_b.out_valid === 1'b1 && bus_b.out_ready === 1'b1) begin
            if (exp_b.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL b_spurious_out: got lane0=%0h, required no output", bus_b.data_out[31:0]);
            end else begin
                em_payload_t e;
                e = exp_b.pop_front();
                chk("b_out_data", bus_b.data_out, e.data);
                chk("b_out_ctrl", bus_b.ctrl_out, e.ctrl);
                chk("b_out_dest", bus_b.dest_out, e.dest);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        em_payload_t p, p2, p3;
        rst_a = 1; rst_b = 1; rst_c = 1;
        flush_a = 0; flush_b = 0; flush_c = 0;
        drive_a(0, '0); drive_b(0, '0); drive_c(0, '0);
        bus_a.out_ready = 0; bus_b.out_ready = 0; bus_c.out_ready = 0;
        tick(); tick();

        chk("a_rst_valid", bus_a.out_valid, 0);
        chk("a_rst_occ", occ_a, 0);
        chk("a_rst_stall", stall_a, 0);
        chk("a_rst_ctrl", bus_a.ctrl_out, 0);
        chk("a_rst_data", bus_a.data_out, 0);
        chk("a_rst_dest", bus_a.dest_out, 0);
        chk("a_rst_in_ready", bus_a.in_ready, 1);
        chk("b_rst_valid", bus_b.out_valid, 0);
        rst_a = 0; rst_b = 0; rst_c = 0;

        // A: stream 1..4 with downstream always ready
        bus_a.out_ready = 1;
        for (int i = 1; i <= 4; i++) begin
            p = mk(32'(i), 4'(i), 5'(i));
            drive_a(1, p);
            exp_a.push_back(p);
            tick();
            chk("a_stream_valid", bus_a.out_valid, 1);
            chk("a_stream_occ", occ_a, 1);
        end
        drive_a(0, '0);
        tick(); tick();
        chk("a_stream_drained", bus_a.out_valid, 0);
        chk("a_stream_stall", stall_a, 0);
        chk("a_stream_sb_empty", exp_a.size(), 0);

        // A: back-pressure fills main then skid; 0xC must be refused
        bus_a.out_ready = 0;
        p = mk(32'hA, C_LOAD, 5'd10); drive_a(1, p); exp_a.push_back(p); tick();
        chk("a_bp_occ1", occ_a, 1);
        chk("a_bp_ready_one", bus_a.in_ready, 1);
        p2 = mk(32'hB, C_STORE, 5'd11); drive_a(1, p2); exp_a.push_back(p2); tick();
        chk("a_bp_occ2", occ_a, 2);
        chk("a_bp_ready_full", bus_a.in_ready, 0);
        p3 = mk(32'hC, C_MULT, 5'd12); drive_a(1, p3); tick();
        chk("a_bp_hold_occ", occ_a, 2);
        chk("a_bp_head", bus_a.data_out, p.data);
        tick();
        chk("a_bp_stall", stall_a, 3);
        drive_a(0, '0);
        bus_a.out_ready = 1;
        tick();
        chk("a_bp_drain_occ1", occ_a, 1);
        tick();
        chk("a_bp_drain_occ0", occ_a, 0);
        tick();
        chk("a_bp_stall_hold", stall_a, 3);
        chk("a_bp_sb_empty", exp_a.size(), 0);

        // A: flush while FULL with a live input offered
        bus_a.out_ready = 0;
        p = mk(32'h11, C_LOAD, 5'd3); drive_a(1, p); exp_a.push_back(p); tick();
        p = mk(32'h22, C_STORE, 5'd4); drive_a(1, p); exp_a.push_back(p); tick();
        chk("a_fl_occ_full", occ_a, 2);
        drive_a(1, mk(32'h33, 4'b1111, 5'd5));
        flush_a = 1;
        exp_a.delete();
        tick();
        flush_a = 0;
        drive_a(0, '0);
        chk("a_fl_valid", bus_a.out_valid, 0);
        chk("a_fl_ctrl", bus_a.ctrl_out, 0);
        chk("a_fl_occ", occ_a, 0);
        chk("a_fl_in_ready", bus_a.in_ready, 1);
        chk("a_fl_stall_kept", stall_a, 5);
        bus_a.out_ready = 1;
        tick(); tick();
        chk("a_fl_no_ghost", bus_a.out_valid, 0);

        // A: reset while FULL with an input offered
        bus_a.out_ready = 0;
        p = mk(32'h44, C_LOAD, 5'd6); drive_a(1, p); exp_a.push_back(p); tick();
        p = mk(32'h55, C_LOAD, 5'd7); drive_a(1, p); exp_a.push_back(p); tick();
        chk("a_rf_occ_full", occ_a, 2);
        chk("a_rf_stall", stall_a, 6);
        drive_a(1, mk(32'h66, 4'b1111, 5'd9));
        rst_a = 1;
        exp_a.delete();
        tick();
        rst_a = 0;
        drive_a(0, '0);
        chk("a_rf_valid", bus_a.out_valid, 0);
        chk("a_rf_occ", occ_a, 0);
        chk("a_rf_stall", stall_a, 0);
        chk("a_rf_ctrl", bus_a.ctrl_out, 0);
        chk("a_rf_data", bus_a.data_out, 0);
        chk("a_rf_dest", bus_a.dest_out, 0);
        chk("a_rf_in_ready", bus_a.in_ready, 1);
        bus_a.out_ready = 1;
        p = mk(32'h77, C_LOAD, 5'd8); drive_a(1, p); exp_a.push_back(p); tick();
        drive_a(0, '0);
        chk("a_post_rst_valid", bus_a.out_valid, 1);
        tick();
        chk("a_post_rst_drain", bus_a.out_valid, 0);
        chk("a_final_sb_empty", exp_a.size(), 0);

        // B: combinational ready follows out_ready while holding an entry
        bus_b.out_ready = 1;
        p = mk(32'h101, C_LOAD, 5'd1); drive_b(1, p); exp_b.push_back(p); #1;
        chk("b_ready_empty", bus_b.in_ready, 1);
        tick();
        chk("b_valid", bus_b.out_valid, 1);
        chk("b_occ", occ_b, 1);
        p = mk(32'h102, C_STORE, 5'd2); drive_b(1, p); exp_b.push_back(p); #1;
        chk("b_ready_mirror1", bus_b.in_ready, 1);
        tick();
        p2 = mk(32'h103, C_MULT, 5'd3); drive_b(1, p2);
        bus_b.out_ready = 0; #1;
        chk("b_ready_mirror0", bus_b.in_ready, 0);
        tick();
        chk("b_hold_data", bus_b.data_out, p.data);
        chk("b_stall", stall_b, 1);
        chk("b_occ_max1", occ_b, 1);
        bus_b.out_ready = 1; exp_b.push_back(p2); #1;
        chk("b_ready_mirror1b", bus_b.in_ready, 1);
        tick();
        chk("b_next_data", bus_b.data_out, p2.data);
        drive_b(0, '0);
        tick();
        chk("b_drained", bus_b.out_valid, 0);
        chk("b_drained_occ", occ_b, 0);
        chk("b_sb_empty", exp_b.size(), 0);

        // C: 4-bit stall counter saturates at 15
        p = mk(32'hC0, C_MULT, 5'd9); drive_c(1, p); tick();
        drive_c(0, '0);
        repeat (5) tick();
        chk("c_stall_5", stall_c, 5);
        repeat (15) tick();
        chk("c_stall_sat", stall_c, 15);
        chk("c_valid_held", bus_c.out_valid, 1);
        chk("c_data_held", bus_c.data_out, p.data);
        chk("c_ctrl_held", bus_c.ctrl_out, C_MULT);
        bus_c.out_ready = 1;
        tick();
        chk("c_stall_stay", stall_c, 15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipeline_stage_register.md
Name: pipeline_stage_register

Overview:
Parametrised pipeline boundary register for the MIPS datapath. It is the generalised successor of the fixed per-stage registers. It carries a control bundle, N data lanes and a destination register index. It adds valid/ready flow control, synchronous flush (bubble insertion), an optional two-entry skid buffer and a saturating back-pressure counter. It is instantiated between any two stages: F/D, D/E, E/M or M/W.

Parameters:
DATA_WIDTH  32  width of one data lane
NUM_LANES  4  number of data lanes (E/M uses ALU, HI, LO, write data)
CTRL_WIDTH  4  control bundle width (write enables, mem-to-reg, etc.)
REG_ADDR_WIDTH  5  destination register index width
SKID_ENABLE  1  1 = two-entry skid buffer with registered in_ready; 0 = single entry, combinational ready
STALL_CNT_WIDTH  16  width of back-pressure counter

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
flush  in  1  discard all held and incoming entries this cycle
in_valid  in  1  upstream entry present
in_ready  out  1  stage can accept this cycle
ctrl_in  in  CTRL_WIDTH  control bundle
data_in  in  NUM_LANES*DATA_WIDTH  lane i at bits [i*DATA_WIDTH +: DATA_WIDTH]
dest_in  in  REG_ADDR_WIDTH  destination register index
out_valid  out  1  downstream entry present
out_ready  in  1  downstream accepts this cycle
ctrl_out  out  CTRL_WIDTH  control bundle, forced 0 when out_valid=0
data_out  out  NUM_LANES*DATA_WIDTH  lane data
dest_out  out  REG_ADDR_WIDTH  destination index
occupancy  out  2  entries held (0..2; max 1 when SKID_ENABLE=0)
stall_count  out  STALL_CNT_WIDTH  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Interface: one clock `clk`; `reset` is synchronous and active-high.
- Transfers: an input transfer occurs when in_valid & in_ready. An output transfer occurs when out_valid & out_ready. Latency is 1 cycle: an accepted entry appears on the outputs the next cycle if the stage was empty.
- Reset: out_valid=0, skid entry invalid, occupancy=0, stall_count=0, and all data/dest/ctrl registers are 0. in_ready=1 in the first cycle after reset.
- Priority per cycle: reset > flush > normal operation.
- Flush:
  - Next cycle out_valid=0, skid invalid and occupancy=0.
  - An input presented in the flush cycle is dropped, even if in_ready=1.
  - Data/dest registers may hold stale values. ctrl_out reads 0 because of the valid gating.
  - stall_count is not cleared.
- ctrl_out gating is combinational: ctrl_out = out_valid ? ctrl_reg : 0. This guarantees bubbles never assert write enables.
- SKID_ENABLE=0:
  - in_ready = out_ready | ~out_valid (combinational).
  - On an input transfer, main register loads and out_valid=1.
  - On an output transfer without an input transfer, out_valid=0.
  - Simultaneous input and output transfers give back-to-back throughput of 1 per cycle.
- SKID_ENABLE=1:
  - in_ready = ~skid_valid, driven from a register with no combinational path from out_ready.
  - States (occupancy): EMPTY(0), ONE(1), FULL(2).
  - EMPTY: input transfer -> ONE (main loaded).
  - ONE, input and output transfer -> ONE (main reloaded).
  - ONE, input transfer without output transfer -> FULL (new entry into skid; main held).
  - ONE, output transfer without input transfer -> EMPTY.
  - FULL: in_ready=0, so no input transfer is possible. Output transfer -> ONE, with main <= skid the same edge.
  - FULL with no output transfer: hold.
  - Ordering is strictly FIFO. Entries are never duplicated or lost except by flush/reset.
- stall_count: increments by 1 each cycle with out_valid & ~out_ready. It holds at all-ones and is cleared only by reset.
- Reset asserted mid-transfer wins: the entry is lost, and outputs match the reset state next cycle.

Decomposition:
- Shared package pipeline_pkg: default widths (DATA_WIDTH, REG_ADDR_WIDTH), the control-bundle bit positions for E/M (reg_write, mem_to_reg, mem_write, hilo_write) and a typedef for the payload struct {ctrl, data lanes, dest}.
- One natural sub-module: pipeline_payload_slot, a payload register with load enable and synchronous clear. It is instantiated twice (main, skid) when SKID_ENABLE=1.

Test Plan:
- Reset then stream: reset 2 cycles, then in_valid=1 with out_ready=1 and data lane0 = 1,2,3,4 on successive cycles -> out_valid rises 1 cycle after the first accept; lane0 out = 1,2,3,4 consecutively; stall_count=0.
- Back-pressure (SKID=1): stream 0xA, 0xB, 0xC with out_ready=0 from cycle 1 -> occupancy 1 then 2; in_ready=0 once FULL; 0xC not accepted; stall_count counts each waiting cycle. Raising out_ready -> outputs 0xA, 0xB, 0xC in order with no duplicates.
- Flush while FULL with in_valid=1, ctrl_in=4'b1111 -> next cycle out_valid=0, ctrl_out=0, occupancy=0, in_ready=1; the flushed-cycle input never appears.
- SKID=0 combinational ready: out_valid=1, out_ready toggling 1,0,1 with in_valid=1 -> in_ready mirrors out_ready; throughput of 1/cycle when ready.
- Saturation: STALL_CNT_WIDTH=4, hold out_valid=1, out_ready=0 for 20 cycles -> stall_count stops at 15.
- Reset mid-FULL: occupancy=2, assert reset one cycle -> all outputs zero, occupancy=0, stall_count=0 next cycle.
